axi_drain_ctrl: RTL

//  Tracks outstanding AXI read and write transactions per requester on the shared cache-subsystem AXI port.

---
 rtl/axi_drain_ctrl.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/axi_drain_ctrl.sv
// ---------------------------------------------------------------------------
// axi_drain_ctrl
//   Outstanding-transaction tracker and drain controller for the shared
//   cache-subsystem AXI port. Keeps one read and one write counter per
//   requester (I$, D$ bypass, D$ data) and gates new AR/AW issue so that
//   no requester exceeds MAX_OUT outstanding transactions per direction.
//   On a drain request the port is brought to a quiescent state and a
//   one-cycle acknowledge is returned.
//
// Ports
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   clr_i                  synchronous clear, same effect as reset
//   ar_* / r_*             AR handshake and R last-beat handshake with requester index
//   aw_* / b_*             AW handshake and B handshake with requester index
//   req_valid_i[N_MST]     per-requester valid raised ahead of the arbiter
//   drain_req_i            level drain request, held until drain_ack_o
//   ar_gate_o / aw_gate_o  per-requester permission to raise a new AR / AW valid
//   drain_ack_o            one-cycle pulse, port quiescent
//   idle_o                 all counters zero
//   err_o                  sticky overflow/underflow flag
// ---------------------------------------------------------------------------
module axi_drain_ctrl #(
    parameter int  N_MST   = 3,
    parameter int  MAX_OUT = 4,
    localparam int CNT_W   = $clog2(MAX_OUT + 1),
    localparam int IDX_W   = (N_MST > 1) ? $clog2(N_MST) : 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clr_i,
    input  logic             ar_valid_i,
    input  logic             ar_ready_i,
    input  logic [IDX_W-1:0] ar_mst_i,
    input  logic             r_valid_i,
    input  logic             r_ready_i,
    input  logic             r_last_i,
    input  logic [IDX_W-1:0] r_mst_i,
    input  logic             aw_valid_i,
    input  logic             aw_ready_i,
    input  logic [IDX_W-1:0] aw_mst_i,
    input  logic             b_valid_i,
    input  logic             b_ready_i,
    input  logic [IDX_W-1:0] b_mst_i,
    input  logic [N_MST-1:0] req_valid_i,
    input  logic             drain_req_i,
    output logic [N_MST-1:0] ar_gate_o,
    output logic [N_MST-1:0] aw_gate_o,
    output logic             drain_ack_o,
    output logic             idle_o,
    output logic             err_o
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_HALT  = 2'd2
    } state_t;

    state_t                       state_r, state_s;
    logic [N_MST-1:0][CNT_W-1:0]  rd_cnt_r, rd_cnt_s;
    logic [N_MST-1:0][CNT_W-1:0]  wr_cnt_r, wr_cnt_s;
    logic [N_MST-1:0]             pend_r, pend_s;
    logic [N_MST-1:0]             req_prev_r;
    logic                         err_r, err_s;
    logic [CNT_W:0]               rd_step_s, wr_step_s;
    logic                         ar_hs_s, r_hs_s, aw_hs_s, b_hs_s;
    logic                         cnt_zero_s, quiet_s;

    // Saturating counter step; MSB of the result flags an overflow/underflow attempt.
    // A simultaneous increment and decrement leaves the count untouched.
    function automatic logic [CNT_W:0] cnt_step(input logic [CNT_W-1:0] cnt,
                                                input logic             inc,
                                                input logic             dec);
        logic [CNT_W:0] res;
        res = {1'b0, cnt};
        if (inc && !dec) begin
            if (cnt == CNT_W'(MAX_OUT)) res = {1'b1, cnt};
            else                        res = {1'b0, cnt + CNT_W'(1)};
        end else if (dec && !inc) begin
            if (cnt == {CNT_W{1'b0}}) res = {1'b1, cnt};
            else                      res = {1'b0, cnt - CNT_W'(1)};
        end else begin
            res = {1'b0, cnt};
        end
        return res;
    endfunction

    assign ar_hs_s    = ar_valid_i & ar_ready_i;
    assign r_hs_s     = r_valid_i & r_ready_i & r_last_i;
    assign aw_hs_s    = aw_valid_i & aw_ready_i;
    assign b_hs_s     = b_valid_i & b_ready_i;
    assign cnt_zero_s = (rd_cnt_r == {(N_MST*CNT_W){1'b0}}) &&
                        (wr_cnt_r == {(N_MST*CNT_W){1'b0}});
    assign quiet_s    = cnt_zero_s && (pend_r == {N_MST{1'b0}});
    assign idle_o     = cnt_zero_s;
    assign err_o      = err_r;

    // Next counter values and sticky error accumulation.
    always_comb begin
        rd_cnt_s  = rd_cnt_r;
        wr_cnt_s  = wr_cnt_r;
        err_s     = err_r;
        rd_step_s = {(CNT_W+1){1'b0}};
        wr_step_s = {(CNT_W+1){1'b0}};
        for (int i = 0; i < N_MST; i++) begin
            rd_step_s   = cnt_step(rd_cnt_r[i],
                                   ar_hs_s && (ar_mst_i == IDX_W'(i)),
                                   r_hs_s  && (r_mst_i  == IDX_W'(i)));
            wr_step_s   = cnt_step(wr_cnt_r[i],
                                   aw_hs_s && (aw_mst_i == IDX_W'(i)),
                                   b_hs_s  && (b_mst_i  == IDX_W'(i)));
            rd_cnt_s[i] = rd_step_s[CNT_W-1:0];
            wr_cnt_s[i] = wr_step_s[CNT_W-1:0];
            err_s       = err_s | rd_step_s[CNT_W] | wr_step_s[CNT_W];
        end
    end

    // Issue gates: capacity-limited in RUN, only in-flight (pending) issues elsewhere.
    always_comb begin
        ar_gate_o = {N_MST{1'b0}};
        aw_gate_o = {N_MST{1'b0}};
        for (int i = 0; i < N_MST; i++) begin
            case (state_r)
                ST_RUN: begin
                    ar_gate_o[i] = (rd_cnt_r[i] < CNT_W'(MAX_OUT)) | pend_r[i];
                    aw_gate_o[i] = (wr_cnt_r[i] < CNT_W'(MAX_OUT)) | pend_r[i];
                end
                ST_DRAIN, ST_HALT: begin
                    ar_gate_o[i] = pend_r[i];
                    aw_gate_o[i] = pend_r[i];
                end
                default: begin
                    ar_gate_o[i] = pend_r[i];
                    aw_gate_o[i] = pend_r[i];
                end
            endcase
        end
    end

    // Pending-issue lock: a valid raised under an open gate keeps that gate open
    // until the requester's address handshake, so a raised valid is never withdrawn.
    always_comb begin
        pend_s = pend_r;
        for (int i = 0; i < N_MST; i++) begin
            if ((ar_hs_s && (ar_mst_i == IDX_W'(i))) || (aw_hs_s && (aw_mst_i == IDX_W'(i)))) begin
                pend_s[i] = 1'b0;
            end else if (req_valid_i[i] && !req_prev_r[i] && (ar_gate_o[i] || aw_gate_o[i])) begin
                pend_s[i] = 1'b1;
            end else begin
                pend_s[i] = pend_r[i];
            end
        end
    end

    // Drain FSM next state; ack marks the DRAIN->HALT transition cycle only.
    always_comb begin
        state_s     = state_r;
        drain_ack_o = 1'b0;
        case (state_r)
            ST_RUN: begin
                if (drain_req_i) state_s = ST_DRAIN;
                else             state_s = ST_RUN;
            end
            ST_DRAIN: begin
                if (!drain_req_i) begin
                    state_s = ST_RUN;
                end else if (quiet_s) begin
                    state_s     = ST_HALT;
                    drain_ack_o = 1'b1;
                end else begin
                    state_s = ST_DRAIN;
                end
            end
            ST_HALT: begin
                if (!drain_req_i) state_s = ST_RUN;
                else              state_s = ST_HALT;
            end
            default: state_s = ST_RUN;
        endcase
    end

    // State registers with asynchronous reset and synchronous clear.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r    <= ST_RUN;
            rd_cnt_r   <= {(N_MST*CNT_W){1'b0}};
            wr_cnt_r   <= {(N_MST*CNT_W){1'b0}};
            pend_r     <= {N_MST{1'b0}};
            req_prev_r <= {N_MST{1'b0}};
            err_r      <= 1'b0;
        end else if (clr_i) begin
            state_r    <= ST_RUN;
            rd_cnt_r   <= {(N_MST*CNT_W){1'b0}};
            wr_cnt_r   <= {(N_MST*CNT_W){1'b0}};
            pend_r     <= {N_MST{1'b0}};
            req_prev_r <= {N_MST{1'b0}};
            err_r      <= 1'b0;
        end else begin
            state_r    <= state_s;
            rd_cnt_r   <= rd_cnt_s;
            wr_cnt_r   <= wr_cnt_s;
            pend_r     <= pend_s;
            req_prev_r <= req_valid_i;
            err_r      <= err_s;
        end
    end

endmodule
